// File: rtl/serial_nibble_adder_if.sv
// rtl/serial_nibble_adder_if.sv - request/result bundle of the serial nibble adder
interface serial_nibble_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             valid;

    modport master (
        output start, a, b, cin, sub,
        input  busy, s, cout, ovf, zero, valid
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, s, cout, ovf, zero, valid
    );
endinterface

// File: rtl/serial_nibble_adder.sv
// rtl/serial_nibble_adder.sv - WIDTH-bit add/subtract using one 4-bit slice, one nibble per clock
module serial_nibble_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_nibble_adder_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [KW-1:0]       k_q;
    logic                carry_q;
    logic                sub_q;
    logic [N-1:0][3:0]   a_q;
    logic [N-1:0][3:0]   b_q;
    logic [N-1:0][3:0]   s_q;
    logic                busy_q;
    logic                valid_q;
    logic                cout_q;
    logic                ovf_q;
    logic                zero_q;

    logic [3:0]          b_nib;
    logic [4:0]          nib_sum;
    logic [N-1:0][3:0]   s_new;
    logic                last;
    logic                b_msb;

    // The slice: b is inverted in subtract mode; the carry register already holds ~cin then.
    always_comb begin
        b_nib   = b_q[k_q] ^ {4{sub_q}};
        nib_sum = {1'b0, a_q[k_q]} + {1'b0, b_nib} + {4'b0000, carry_q};
        s_new   = s_q;
        s_new[k_q] = nib_sum[3:0];
        last    = (k_q == KW'(N - 1));
        b_msb   = b_q[N-1][3] ^ sub_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub ? ~bus.cin : bus.cin;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_new;
                    carry_q <= nib_sum[4];
                    k_q     <= k_q + KW'(1);
                    if (last) begin
                        cout_q  <= nib_sum[4];
                        ovf_q   <= (a_q[N-1][3] == b_msb) && (s_new[N-1][3] != a_q[N-1][3]);
                        zero_q  <= (s_new == '0);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        k_q     <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb/tb_serial_nibble_adder.sv - directed self-checking bench for serial_nibble_adder
module tb_serial_nibble_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   saw_valid;

    always #5 clk = ~clk;

    serial_nibble_adder_if #(.WIDTH(16)) m16 ();
    serial_nibble_adder_if #(.WIDTH(4))  m4 ();

    serial_nibble_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(m16.slave));
    serial_nibble_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(m4.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle16(input string tag);
        chk({tag, "_s"}, 32'(m16.s), 32'h0);
        chk({tag, "_busy"}, 32'(m16.busy), 32'h0);
        chk({tag, "_valid"}, 32'(m16.valid), 32'h0);
        chk({tag, "_cout"}, 32'(m16.cout), 32'h0);
        chk({tag, "_ovf"}, 32'(m16.ovf), 32'h0);
        chk({tag, "_zero"}, 32'(m16.zero), 32'h0);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                         input logic tsub, input logic [15:0] es, input logic ec,
                         input logic eo, input logic ez, input string tag);
        @(negedge clk);
        m16.a = ta; m16.b = tb_; m16.cin = tcin; m16.sub = tsub; m16.start = 1'b1;
        @(negedge clk);
        m16.start = 1'b0;
        m16.a = 16'hDEAD; m16.b = 16'hBEEF; m16.cin = ~tcin; m16.sub = ~tsub;
        chk({tag, "_busy_e0"}, 32'(m16.busy), 32'h1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_busy_mid"}, {30'h0, m16.busy, m16.valid}, 32'h2);
        end
        @(negedge clk);
        chk({tag, "_valid_e4"}, {30'h0, m16.busy, m16.valid}, 32'h1);
        chk({tag, "_s"}, 32'(m16.s), 32'(es));
        chk({tag, "_flags"}, {29'h0, m16.cout, m16.ovf, m16.zero}, {29'h0, ec, eo, ez});
        @(negedge clk);
        chk({tag, "_valid_fall"}, 32'(m16.valid), 32'h0);
    endtask

    initial begin
        m16.start = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0; m16.sub = 1'b0;
        m4.start = 1'b0;  m4.a = '0;  m4.b = '0;  m4.cin = 1'b0;  m4.sub = 1'b0;

        // reset held while start toggles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m16.start = ~m16.start;
            m16.a = 16'h1111; m16.b = 16'h2222;
        end
        chk_idle16("reset");
        @(negedge clk);
        m16.start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle16("post_reset");

        run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, "add");
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "carry_zero");
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "ovf");
        run16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
        run16(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0, "sub_cin");

        // start pulse during a running add is ignored
        @(negedge clk);
        m16.a = 16'h0001; m16.b = 16'h0002; m16.cin = 1'b0; m16.sub = 1'b0; m16.start = 1'b1;
        @(negedge clk);
        m16.start = 1'b0;
        @(negedge clk);
        m16.a = 16'h1111; m16.b = 16'h1111; m16.start = 1'b1;
        @(negedge clk);
        m16.start = 1'b0;
        chk("ignore_busy", 32'(m16.busy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("ignore_valid", 32'(m16.valid), 32'h1);
        chk("ignore_s", 32'(m16.s), 32'h0003);
        @(negedge clk);
        chk("ignore_no_restart", {30'h0, m16.busy, m16.valid}, 32'h0);

        // reset in the middle of an operation
        @(negedge clk);
        m16.a = 16'h00FF; m16.b = 16'h0001; m16.start = 1'b1;
        @(negedge clk);
        m16.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle16("abort");
        saw_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m16.valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", 32'(saw_valid), 32'h0);
        chk_idle16("abort_after");

        // WIDTH = 4: single-nibble latency
        @(negedge clk);
        m4.a = 4'd7; m4.b = 4'd2; m4.cin = 1'b0; m4.sub = 1'b0; m4.start = 1'b1;
        @(negedge clk);
        m4.start = 1'b0;
        chk("w4_busy_e0", {30'h0, m4.busy, m4.valid}, 32'h2);
        @(negedge clk);
        chk("w4_valid_e1", {30'h0, m4.busy, m4.valid}, 32'h1);
        chk("w4_s", 32'(m4.s), 32'h9);
        chk("w4_flags", {29'h0, m4.cout, m4.ovf, m4.zero}, 32'h2);
        @(negedge clk);
        chk("w4_valid_fall", 32'(m4.valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

- Parametrised, multi-cycle adder/subtractor for WIDTH-bit operands.
- Processes one 4-bit nibble per clock, least significant first, and carries between nibbles in a register.
- It is the WIDTH-general successor of the single-nibble adder: it adds subtract mode, a start/busy/valid handshake, and signed-overflow and zero flags.
- It sits in the datapath wherever operands wider than 4 bits must be summed using one 4-bit adder slice.

## Interface

Parameters:

- WIDTH, default 16: operand and result width. Must be a multiple of 4 and ≥ 4. Number of nibbles N = WIDTH/4.

Ports:

- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  reset. Asynchronous assert, active-low.
- start  input  1  request a new operation. Sampled only when busy = 0.
- a  input  WIDTH  operand A. Latched when start is accepted.
- b  input  WIDTH  operand B. Latched when start is accepted.
- cin  input  1  carry-in (add mode) or borrow-in (sub mode). Latched when start is accepted.
- sub  input  1  0 = add, 1 = subtract. Latched when start is accepted.
- busy  output  1  high while an operation is in progress.
- s  output  WIDTH  result register.
- cout  output  1  carry out of the MSB nibble. In sub mode, cout = 0 means a borrow occurred.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  high when s == 0.
- valid  output  1  one-cycle pulse marking that s, cout, ovf and zero are final.

## Operation

States:

- IDLE. When start = 1 at a rising edge:
  - latch a, b and sub;
  - load the carry register with c0 = sub ? ~cin : cin;
  - clear the nibble counter k to 0;
  - go to RUN.
- RUN. Each edge computes {c, s[4k+3:4k]} = a_k + (b_k ^ {4{sub}}) + c, where a_k and b_k are nibble k of the latched operands.
  - Nibble k of s is written and the carry register is updated.
  - k increments.
  - On the edge that writes nibble N−1: set cout, ovf and zero, pulse valid, return to IDLE.

Arithmetic:

- Add mode: s = (a + b + cin) mod 2^WIDTH.
- Sub mode: s = (a − b − cin) mod 2^WIDTH, implemented as a + ~b + ~cin.
- ovf = (a[W−1] == b'[W−1]) && (s[W−1] != a[W−1]), where b' = b ^ {WIDTH{sub}}.
- zero is computed on the complete final result.

Register and handshake rules:

- s is a working register. Nibbles above k keep their previous values during RUN. s is meaningful only while valid = 1 and afterwards until the next accepted start.
- cout, ovf and zero hold their last values until the next completion.
- start is ignored while busy = 1. There is no queuing.
- a, b, cin and sub may change freely after acceptance; the latched copies are used.

Reset:

- Reset asserted at any time, including mid-operation: state = IDLE, k = 0, carry = 0, busy = valid = cout = ovf = zero = 0, s = 0.
- An aborted operation never produces valid.

## Timing

- Acceptance: start sampled high at edge E0 with busy = 0. busy = 1 after E0.
- Nibble i is written at edge E(i+1), for i = 0…N−1.
- At edge EN:
  - busy becomes 0;
  - valid becomes 1;
  - the flags are updated.
- valid falls at E(N+1).
- Latency is N cycles from accepting edge to valid.
- A new start can be accepted no earlier than E(N+1), giving a throughput of one operation per N+1 cycles.
- start held high continuously restarts at every E(k·(N+1)).
- WIDTH = 4 (N = 1): busy lasts one cycle and valid asserts at E1.

## Test plan

- Reset (WIDTH = 16): hold rst_n = 0 with start toggling. Required: s = 0, busy = valid = cout = ovf = zero = 0. Release reset with no start: outputs unchanged.
- Add: a = 0x1234, b = 0x0FFF, cin = 0, sub = 0. Required:
  - busy high for 4 cycles;
  - valid pulse at E4;
  - s = 0x2233, cout = 0, ovf = 0, zero = 0.
- Carry chain and zero: a = 0xFFFF, b = 0x0001, cin = 0. Required: s = 0x0000, cout = 1, zero = 1, ovf = 0.
- Signed overflow: a = 0x7FFF, b = 0x0001. Required: s = 0x8000, ovf = 1, cout = 0.
- Subtract:
  - a = 0x0005, b = 0x0007, cin = 0, sub = 1. Required: s = 0xFFFE, cout = 0 (borrow), ovf = 0.
  - Then a = 0x0010, b = 0x0001, cin = 1, sub = 1. Required: s = 0x000E, cout = 1.
- Handshake and abort:
  - Pulse start with new operands at E2 of a running add. Required: ignored, first result unchanged.
  - Assert rst_n = 0 during E2 of the next operation. Required: no valid pulse, all outputs 0.
  - WIDTH = 4 instance with a = 7, b = 2. Required: s = 9 with valid at E1.
